dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the CPU core: the target end of the dmem request/ACK handshake that the writeback stage waits on.
- Accepts one load/store request at a time from the MEM stage and models a configurable-latency word-organised SRAM.
- Commits stores with byte-lane enables.
- Returns the full aligned word on loads; the writeback stage does the byte/half extraction and sign extension.

Parameters:
- XLEN, 32, data and address width.
- DEPTH_WORDS, 1024, number of XLEN-bit words; power of two.
- LATENCY, 1, cycles from request acceptance to ACK; legal range 1..15.
- INIT_FILE, "", optional $readmemh image loaded at elaboration; empty means no preload.

Ports:
- clock_i  in  1  core clock.
- nreset_i  in  1  reset.
- dmem_req_i  in  1  request valid from MEM stage.
- dmem_we_i  in  1  1 = store, 0 = load.
- dmem_addr_i  in  XLEN  byte address.
- dmem_wdata_i  in  XLEN  store data, right-aligned.
- dmem_size_i  in  2  BYTE=00, HWORD=01, WORD=10 (func3[1:0]).
- dmem_stall_i  in  1  downstream pipeline stall; holds the response.
- dmem_rdata_o  out  XLEN  aligned word read; valid while dmem_ACK_o.
- dmem_ACK_o  out  1  transaction complete.
- dmem_err_o  out  1  misaligned or illegal size; valid with ACK.

Interface: reset nreset_i, asynchronous, active-low; clock clock_i.

Behaviour:
- Reset values: dmem_ACK_o=0, dmem_err_o=0, dmem_rdata_o=0, state IDLE, wait counter 0. Memory contents are not reset.
- Reset asserted mid-transaction aborts it: no write occurs, and ACK stays low.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If dmem_req_i=1: latch we, addr, wdata, size; load counter with LATENCY-1.
  - Go to RESP if LATENCY=1, else go to WAIT.
- WAIT:
  - Decrement counter each cycle.
  - When counter==1: perform the access and go to RESP.
- RESP:
  - dmem_ACK_o=1.
  - If dmem_stall_i=1: stay in RESP; ACK, rdata and err held stable, and no second write occurs.
  - If dmem_stall_i=0: go to IDLE.
- Access timing:
  - The memory access (read sample or store commit) happens exactly once, on the clock edge entering RESP.
  - ACK rises LATENCY cycles after the accepting edge.
- Back-to-back requests: a new request can be accepted earliest in the cycle after the unstalled RESP cycle. Minimum spacing is LATENCY+1 cycles.
- Request inputs are sampled only at acceptance. Deasserting dmem_req_i or changing addr/data during WAIT or RESP has no effect, and the transaction completes normally.
- Indexing: word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Load: rdata is the whole word at the index, unshifted. Outside RESP, rdata holds the last returned value.
- Store byte enables (be) and lane data (lane = addr[1:0]):
  - BYTE: be = 0001<<lane; data = wdata[7:0] replicated to all 4 lanes.
  - HWORD: be = 0011<<lane; data = wdata[15:0] replicated to both halves.
  - WORD: be = 1111; data = wdata.
  - Unselected bytes are unchanged.
- Errors: HWORD with addr[0]=1, WORD with addr[1:0]!=0, or size=11 give dmem_err_o=1 with ACK. In that case there is no write and rdata=0. Handshake timing is unchanged.
- A load after a store to the same word returns the updated value; the store commits before the later read samples.

Decomposition:
- Shared package cpu_core_pkg holds:
  - the mem_size_t encodings BYTE/HWORD/WORD;
  - the new typedef dmem_state_t {IDLE, WAIT, RESP};
  - localparam DMEM_LAT_W = 4.
- One combinational sub-module, dmem_lane_align: from size, addr[1:0] and wdata it produces the 4-bit byte enable, the replicated store data and the misalign flag.
- The storage array and FSM stay in dmem_responder.

Test Plan:
- Reset mid-WAIT (LATENCY=3): assert nreset_i low one cycle after accepting a store of 0xDEADBEEF to 0x10 -> ACK never rises; a later load of 0x10 returns the preload value.
- Store then load (LATENCY=1): store WORD 0x12345678 to 0x40, then load 0x40 -> ACK one cycle after each accept; rdata = 0x12345678; err=0.
- Byte/half lanes: store BYTE 0xAB to 0x41, then HWORD 0xCDEF to 0x42 over word 0x12345678 -> load 0x40 returns 0xCDEFAB78.
- Stall hold: load with dmem_stall_i=1 for 3 cycles during RESP -> ACK high for 4 cycles, rdata stable. A store under stall writes once: a read-modify check shows no double effect.
- Misaligned: WORD store to 0x42 and HWORD load from 0x43 -> ACK with err=1, rdata=0; memory at 0x40 unchanged.
- Latency and wrap (LATENCY=4, DEPTH_WORDS=1024): store to 0x1000 then load 0x0000 -> ACK exactly 4 cycles after accept; load returns the stored value, showing the address wrap.

Source files
------------

// File: rtl/cpu_core_pkg.sv
// Shared CPU-core types: memory access sizes, dmem responder states and
// the width of its latency counter.
package cpu_core_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HWORD = 2'b01,
        WORD  = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

    localparam int DMEM_LAT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Store lane steering: byte enables, lane-replicated store data and the
// misalignment / illegal-size flag for one dmem access.
module dmem_lane_align
    import cpu_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] wdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] lane_data,
    output logic            misalign
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        be        = 4'b0000;
        lane_data = wdata;
        misalign  = 1'b0;
        case (size)
            BYTE: begin
                be        = 4'b0001 << lane;
                lane_data = {(XLEN/8){wdata[7:0]}};
            end
            HWORD: begin
                be        = 4'b0011 << lane;
                lane_data = {(XLEN/16){wdata[15:0]}};
                misalign  = lane[0];
            end
            WORD: begin
                be        = 4'b1111;
                misalign  = (lane != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
        // A faulting access must never touch the array.
        if (misalign) begin
            be = 4'b0000;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the dmem request/ACK handshake,
// modelling a word-organised SRAM with a fixed access latency.
module dmem_responder
    import cpu_core_pkg::*;
#(
    parameter int    XLEN        = 32,
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic            clock_i,
    input  logic            nreset_i,
    input  logic            dmem_req_i,
    input  logic            dmem_we_i,
    input  logic [XLEN-1:0] dmem_addr_i,
    input  logic [XLEN-1:0] dmem_wdata_i,
    input  logic [1:0]      dmem_size_i,
    input  logic            dmem_stall_i,
    output logic [XLEN-1:0] dmem_rdata_o,
    output logic            dmem_ACK_o,
    output logic            dmem_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t           state;
    logic [DMEM_LAT_W-1:0] cnt;
    logic                  lat_we;
    logic [IDX_W+1:0]      lat_addr;
    logic [XLEN-1:0]       lat_wdata;
    logic [1:0]            lat_size;
    logic                  ack;
    logic                  err;
    logic [XLEN-1:0]       rdata;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // In IDLE the live request drives the access path so LATENCY=1 can
    // complete on the accepting edge; later the latched copy takes over.
    logic             in_idle;
    logic             accept;
    logic             do_access;
    logic             sel_we;
    logic [IDX_W+1:0] sel_addr;
    logic [XLEN-1:0]  sel_wdata;
    logic [1:0]       sel_size;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [XLEN-1:0]  lane_data;
    logic             misalign;
    logic             addr_unused;

    assign in_idle     = (state == IDLE);
    assign accept      = in_idle && dmem_req_i;
    assign sel_we      = in_idle ? dmem_we_i                 : lat_we;
    assign sel_addr    = in_idle ? dmem_addr_i[IDX_W+1:0]    : lat_addr;
    assign sel_wdata   = in_idle ? dmem_wdata_i              : lat_wdata;
    assign sel_size    = in_idle ? dmem_size_i               : lat_size;
    assign idx         = sel_addr[IDX_W+1:2];
    assign addr_unused = ^dmem_addr_i[XLEN-1:IDX_W+2];

    // Gated by reset so an access never lands while the core is held in reset.
    assign do_access = nreset_i &&
                       ((accept && (LATENCY == 1)) ||
                        ((state == WAIT) && (cnt == DMEM_LAT_W'(1))));

    dmem_lane_align #(.XLEN(XLEN)) u_lane_align (
        .size      (sel_size),
        .lane      (sel_addr[1:0]),
        .wdata     (sel_wdata),
        .be        (be),
        .lane_data (lane_data),
        .misalign  (misalign)
    );

    // NOTE: the storage array is deliberately left out of reset; only the handshake state resets.
    always_ff @(posedge clock_i) begin
        if (do_access && sel_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
    end

    // NOTE: state and outputs update with non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= 2'b00;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmem_req_i) begin
                        lat_we    <= dmem_we_i;
                        lat_addr  <= dmem_addr_i[IDX_W+1:0];
                        lat_wdata <= dmem_wdata_i;
                        lat_size  <= dmem_size_i;
                        cnt       <= DMEM_LAT_W'(LATENCY - 1);
                        state     <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - DMEM_LAT_W'(1);
                    if (cnt == DMEM_LAT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (!dmem_stall_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (do_access) begin
                ack <= 1'b1;
                err <= misalign;
                if (misalign) begin
                    rdata <= '0;
                end else if (!sel_we) begin
                    rdata <= mem[idx];
                end
            end else if ((state == RESP) && !dmem_stall_i) begin
                ack <= 1'b0;
                err <= 1'b0;
            end
        end
    end

    assign dmem_rdata_o = rdata;
    assign dmem_ACK_o   = ack;
    assign dmem_err_o   = err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders (LATENCY 1, 3, 4) driven by directed
// scenarios and random traffic, checked against a byte-level memory model.
module tb_dmem_responder;

    localparam int NDUT  = 3;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        nreset;
    logic        req   [NDUT];
    logic        we    [NDUT];
    logic [31:0] addr  [NDUT];
    logic [31:0] wdata [NDUT];
    logic [1:0]  size  [NDUT];
    logic        stall [NDUT];
    logic [31:0] rdata [NDUT];
    logic        ack   [NDUT];
    logic        err   [NDUT];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference memory: one word array per DUT plus a flag for fully-known words.
    logic [31:0] mdl   [NDUT][DEPTH];
    bit          known [NDUT][DEPTH];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_responder #(
            .XLEN        (32),
            .DEPTH_WORDS (DEPTH),
            .LATENCY     ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clock_i      (clk),
            .nreset_i     (nreset),
            .dmem_req_i   (req[g]),
            .dmem_we_i    (we[g]),
            .dmem_addr_i  (addr[g]),
            .dmem_wdata_i (wdata[g]),
            .dmem_size_i  (size[g]),
            .dmem_stall_i (stall[g]),
            .dmem_rdata_o (rdata[g]),
            .dmem_ACK_o   (ack[g]),
            .dmem_err_o   (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called and returns at a negedge. Drives one request, checks latency,
    // response, stall hold and release, then updates the model.
    task automatic do_txn(input int d, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz,
                          input int nstall, input string tag);
        bit          exp_err;
        int          idx;
        int          n;
        int          nb;
        int          pos;
        logic [31:0] word;
        logic [31:0] exp_rd;
        bit          chk_rd;

        exp_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        idx     = int'(a[11:2]);
        chk_rd  = !w && (exp_err || known[d][idx]);
        exp_rd  = exp_err ? 32'h0 : mdl[d][idx];

        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; size[d] = sz; stall[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Scramble everything: only the accepted values may matter now.
        req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
        size[d] = 2'($urandom);
        n = 1;
        while (ack[d] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s.latency", tag), n, lat_of(d));
        check($sformatf("%s.err", tag), {31'h0, err[d]}, {31'h0, exp_err});
        if (chk_rd) check($sformatf("%s.rdata", tag), rdata[d], exp_rd);

        stall[d] = (nstall > 0);
        for (int k = 0; k < nstall; k++) begin
            @(negedge clk);
            if (k == nstall - 1) stall[d] = 1'b0;
            check($sformatf("%s.stall_ack%0d", tag, k), {31'h0, ack[d]}, 32'h1);
            if (chk_rd) check($sformatf("%s.stall_rdata%0d", tag, k), rdata[d], exp_rd);
        end
        @(negedge clk);
        check($sformatf("%s.ack_drop", tag), {31'h0, ack[d]}, 32'h0);

        if (w && !exp_err) begin
            nb   = 1 << sz;
            word = mdl[d][idx];
            for (int k = 0; k < nb; k++) begin
                pos = int'(a[1:0]) + k;
                word[8*pos +: 8] = wd[8*k +: 8];
            end
            mdl[d][idx] = word;
            if (sz == 2'b10) known[d][idx] = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_ack;
        nreset = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
            size[d] = 2'b00; stall[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset.ack%0d", d), {31'h0, ack[d]}, 32'h0);
            check($sformatf("reset.err%0d", d), {31'h0, err[d]}, 32'h0);
            check($sformatf("reset.rdata%0d", d), rdata[d], 32'h0);
        end
        nreset = 1'b1;
        @(negedge clk);

        // LATENCY=1: store/load, byte and half lanes.
        do_txn(0, 1, 32'h40, 32'h1234_5678, 2'b10, 0, "sw40");
        do_txn(0, 0, 32'h40, 32'h0,         2'b10, 0, "lw40");
        check("lw40.const", rdata[0], 32'h1234_5678);
        do_txn(0, 1, 32'h41, 32'h0000_00AB, 2'b00, 0, "sb41");
        do_txn(0, 1, 32'h42, 32'h0000_CDEF, 2'b01, 0, "sh42");
        do_txn(0, 0, 32'h40, 32'h0,         2'b10, 0, "lw40b");
        check("lanes.const", rdata[0], 32'hCDEF_AB78);

        // Stall hold on a load and on a store.
        do_txn(0, 0, 32'h40, 32'h0,         2'b10, 3, "stall_lw");
        do_txn(0, 1, 32'h44, 32'h0000_0000, 2'b10, 0, "sw44");
        do_txn(0, 1, 32'h45, 32'h0000_0077, 2'b00, 2, "stall_sb");
        do_txn(0, 0, 32'h44, 32'h0,         2'b10, 0, "lw44");
        check("stall_sb.const", rdata[0], 32'h0000_7700);

        // Misaligned and illegal-size accesses.
        do_txn(0, 1, 32'h42, 32'hFFFF_FFFF, 2'b10, 0, "sw42_mis");
        do_txn(0, 0, 32'h43, 32'h0,         2'b01, 0, "lh43_mis");
        do_txn(0, 0, 32'h40, 32'h0,         2'b11, 1, "size11");
        do_txn(0, 0, 32'h40, 32'h0,         2'b10, 0, "lw40_after_mis");
        check("mis.const", rdata[0], 32'hCDEF_AB78);

        // LATENCY=3: reset in the middle of WAIT aborts the store.
        do_txn(1, 1, 32'h10, 32'h1111_1111, 2'b10, 0, "sw10");
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h10; wdata[1] = 32'hDEAD_BEEF; size[1] = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        nreset  = 1'b0;
        saw_ack = 1'b0;
        #1;
        check("abort.rdata", rdata[1], 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 1) nreset = 1'b1;
            if (ack[1] !== 1'b0) saw_ack = 1'b1;
        end
        check("abort.no_ack", {31'h0, saw_ack}, 32'h0);
        do_txn(1, 0, 32'h10, 32'h0, 2'b10, 0, "lw10");
        check("abort.const", rdata[1], 32'h1111_1111);

        // LATENCY=4: address wrap modulo DEPTH*4.
        do_txn(2, 1, 32'h1000, 32'hA5A5_0F0F, 2'b10, 0, "sw1000");
        do_txn(2, 0, 32'h0000, 32'h0,         2'b10, 0, "lw0000");
        check("wrap.const", rdata[2], 32'hA5A5_0F0F);

        // Random traffic in a 16-word window, aliased through random upper bits.
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 16; i++) begin
                do_txn(d, 1, 32'(i * 4), $urandom, 2'b10, 0, $sformatf("init%0d_%0d", d, i));
            end
            for (int i = 0; i < 40; i++) begin
                do_txn(d, 1'($urandom),
                       ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
                       $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2),
                       $sformatf("rnd%0d_%0d", d, i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
